// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM bus arbiter.
// Holds the FSM encoding, default byte-enable width and grant-index sizing.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DW_DEF = 16;
  localparam int BE_W   = DW_DEF / 8;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner picker for the SRAM arbiter.
// Fixed lowest-index priority, or round-robin with SRAM_ARB_ROUND_ROBIN_EN.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GW   = gid_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [GW-1:0]   last_grant,
  output logic [NREQ-1:0] onehot,
  output logic [GW-1:0]   idx,
  output logic            any_valid
);

  logic [GW-1:0] c;

  assign any_valid = |valid;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Walk from the farthest slot inward so the nearest one after
  // last_grant is written last and wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    c      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = GW'((int'(last_grant) + k) % NREQ);
      if (valid[c]) begin
        onehot    = '0;
        onehot[c] = 1'b1;
        idx       = c;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_grant;

  always_comb begin
    onehot = '0;
    idx    = '0;
    c      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = GW'(i);
      if (valid[c]) begin
        onehot    = '0;
        onehot[c] = 1'b1;
        idx       = c;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external SRAM controller between NREQ requesters.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = DW_DEF,
  localparam int BW  = DW / 8,
  localparam int GW  = gid_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*BW-1:0] req_be,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  output logic              m_we,
  output logic [BW-1:0]     m_be,
  input  logic              m_done,
  input  logic [DW-1:0]     m_rdata,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  state_t state, state_d;

  logic [NREQ-1:0] win;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   lg;
  logic            any;
  logic            accept;

  assign accept = (state == IDLE) && any;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= GW'(NREQ - 1);
    else if (accept)
      last_grant <= win_idx;
  end

  assign lg = last_grant;
`else
  assign lg = '0;
`endif

  sram_arb_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (lg),
    .onehot     (win),
    .idx        (win_idx),
    .any_valid  (any)
  );

  assign req_ready = accept ? win : '0;
  assign m_valid   = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (any)     state_d = ISSUE;
      ISSUE:   if (m_ready) state_d = WAIT;
      WAIT:    if (m_done)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_we      <= 1'b0;
      m_be      <= '0;
      grant_id  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      rsp_valid <= '0;
      if (accept) begin
        m_addr   <= req_addr[int'(win_idx)*AW +: AW];
        m_wdata  <= req_wdata[int'(win_idx)*DW +: DW];
        m_we     <= req_we[win_idx];
        m_be     <= req_be[int'(win_idx)*BW +: BW];
        grant_id <= win_idx;
      end
      // Completion is routed back to whoever owns the bus now.
      if (state == WAIT && m_done) begin
        rsp_rdata <= m_rdata;
        rsp_valid <= NREQ'(1) << grant_id;
      end
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 16-bit SRAM bus controller between NREQ requesters, e.g. CPU fetch/data port and the programmer/loader port.
- Accepts one request at a time and holds the grant for the whole transaction.
- Drives the controller's request/response handshake, then routes the completion back to the originating requester.
- Sits directly above the external-SRAM controller in the top-level, below CPU and loader.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 32, request address width (byte address).
- DW, 16, data width; byte-enable width is DW/8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot pulse: request accepted this cycle.
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- req_we  in  NREQ  1 = write, 0 = read.
- req_be  in  NREQ*DW/8  byte enables (bit1 = high byte / BHE).
- rsp_valid  out  NREQ  one-hot, single-cycle completion strobe.
- rsp_rdata  out  DW  read data, shared; valid only with rsp_valid.
- m_valid  out  1  request to the SRAM controller.
- m_ready  in  1  controller accepts request.
- m_addr  out  AW  latched address.
- m_wdata  out  DW  latched write data.
- m_we  out  1  latched write flag.
- m_be  out  DW/8  latched byte enables.
- m_done  in  1  controller completion (read data valid or write finished).
- m_rdata  in  DW  controller read data.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  clog2(NREQ)  index of current or last owner.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - req_ready=0, rsp_valid=0, m_valid=0, busy=0, grant_id=0.
  - m_addr, m_wdata, m_we, m_be and rsp_rdata = 0.
  - Reset mid-transaction abandons it without emitting rsp_valid; the controller is reset in the same cycle.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - When any req_valid is high, the picker selects winner w.
  - req_ready[w]=1 combinationally in that cycle.
  - req fields of w are latched into m_* registers and grant_id<=w; next state ISSUE.
  - No other req_ready bit is ever asserted.
- ISSUE:
  - m_valid=1 with the latched fields, held stable until m_ready.
  - On m_valid&&m_ready: next state WAIT, and m_valid deasserts next cycle.
- WAIT:
  - On m_done: rsp_rdata<=m_rdata, rsp_valid[grant_id]<=1 for exactly one cycle (registered), next state IDLE.
  - rsp_rdata is also updated on writes; its contents are don't-care there.
- m_done outside WAIT is ignored.
- Latency: accept at cycle T, m_valid at T+1; if m_ready at T+1 and m_done at T+2, then rsp_valid at T+3.
  - A new accept is possible at T+3 (same cycle rsp_valid is seen).
- Requester rules:
  - Must hold req_* stable while req_valid=1 and not yet accepted.
  - May drop req_valid before acceptance; it is then not serviced.
- Fixed priority (default): lowest index wins.
  - Simultaneous requests are served sequentially, one per transaction.
- busy high in ISSUE and WAIT.
- Requests arriving while busy wait; nothing is queued (depth 1).

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin pointer last_grant, reset to NREQ-1, so requester 0 wins first after reset.
  - Search starts at last_grant+1, wrapping modulo NREQ.
  - last_grant<=w on each accept.
  - Requester i re-wins only when no other requester is pending.
- Undefined: fixed priority as above; no pointer register.

Decomposition:
- Package sram_arb_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - BE_W = DW/8;
  - the grant-index width function.
- One combinational sub-module, sram_arb_pick: takes req_valid and last_grant, outputs a one-hot winner and its index plus any_valid. It implements both the fixed-priority and round-robin variants under the macro.
- FSM and latches stay in sram_arbiter.

Test Plan:
- Single read: req0 read addr 0x0000_0010, be=2'b11; controller m_ready immediate, m_done one cycle later with rdata=0xBEEF -> rsp_valid[0] at T+3, rsp_rdata=0xBEEF, m_addr=0x10, m_we=0.
- Simultaneous: req0 write 0x1234 to 0x20 and req1 read 0x40, both at T, fixed priority -> req0 served first, req1 accepted at T+3 without being dropped; two rsp pulses in order 0 then 1.
- Round-robin (macro on): req0 and req1 held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Backpressure: m_ready low for 5 cycles in ISSUE -> m_valid and m_addr/m_wdata/m_be stable all 5 cycles; no req_ready asserted while busy.
- Byte write: req1 write be=2'b10, wdata=0xAB00 -> m_be=2'b10, m_we=1; rsp_valid[1] is a single cycle.
- Reset in WAIT: assert rst_n=0 one cycle before m_done -> no rsp_valid; next cycle all outputs at reset values, state IDLE, busy=0.
